// File: rtl/bpu_pkg.sv
// Shared types and helpers for the front-end branch predictor.
//   ctr_t            : 2-bit saturating pattern-history counter
//   WEAKLY_NOT_TAKEN : value every counter is swept to after reset
//   ctrl_state_e     : table controller states (INIT sweep, RUN service)
//   bpu_entry_t      : in-flight prediction record {index, prediction, counter}
//   sat_update()     : saturating counter update on a resolved outcome
package bpu_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t WEAKLY_NOT_TAKEN = 2'b01;

  // Index field is sized for the widest table supported; each user keeps
  // only the low IW bits, so unused upper bits are constant and trimmed.
  localparam int MAX_IW = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic [MAX_IW-1:0] index;
    logic              prediction;
    ctr_t              counter;
  } bpu_entry_t;

  function automatic ctr_t sat_update(ctr_t ctr, logic taken);
    ctr_t res;
    if (taken) begin
      res = (ctr == 2'b11) ? ctr : ctr + 2'd1;
    end else begin
      res = (ctr == 2'b00) ? ctr : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/prediction_fifo.sv
// In-order tracker for in-flight predictions.
//   alloc_i/alloc_index_i     : append an entry at the tail (read just issued)
//   commit_i/commit_counter_i : late counter data for the oldest uncommitted entry
//   pop_i                     : retire the head entry (resolution accepted)
//   flush_i                   : drop every entry, pointers back to 0
//   head_o                    : oldest entry
//   count_o / committed_o     : allocated entries / entries with counter data
module prediction_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   alloc_i,
  input  logic [IW-1:0]          alloc_index_i,
  input  logic                   commit_i,
  input  logic [1:0]             commit_counter_i,
  input  logic                   pop_i,
  output bpu_entry_t             head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [$clog2(DEPTH):0] committed_o
);

  localparam int PW = $clog2(DEPTH);

  bpu_entry_t    entries_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] commit_ptr;
  logic [PW:0]   count_q, count_d;
  logic [PW:0]   committed_q, committed_d;

  // Reads return in order, so the entry awaiting data sits just past the
  // committed ones. When committed == DEPTH no commit can be pending.
  assign commit_ptr = head_q + committed_q[PW-1:0];

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    committed_d = committed_q;
    if (flush_i) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      committed_d = '0;
    end else begin
      if (alloc_i) tail_d = tail_q + PW'(1);
      if (pop_i)   head_d = head_q + PW'(1);
      count_d     = count_q + (PW+1)'(alloc_i) - (PW+1)'(pop_i);
      committed_d = committed_q + (PW+1)'(commit_i) - (PW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      committed_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      committed_q <= committed_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by the counts.
  // Alloc and commit never target the same slot in one cycle.
  always_ff @(posedge clk_i) begin
    if (alloc_i && !flush_i) begin
      entries_q[tail_q].index      <= MAX_IW'(alloc_index_i);
      entries_q[tail_q].prediction <= 1'b0;
      entries_q[tail_q].counter    <= WEAKLY_NOT_TAKEN;
    end
    if (commit_i && !flush_i) begin
      entries_q[commit_ptr].prediction <= commit_counter_i[1];
      entries_q[commit_ptr].counter    <= commit_counter_i;
    end
  end

  assign head_o      = entries_q[head_q];
  assign count_o     = count_q;
  assign committed_o = committed_q;

endmodule

// File: rtl/branch_predictor_controller.sv
// Sequencer and port arbiter for the single-ported gshare pattern history
// table. Sweeps every counter to weakly-not-taken after reset, then shares
// the table port between prediction reads and resolution writes (writes win).
//   flush_i                      : drop unresolved predictions
//   predict_valid/index/ready    : fetch-side prediction request
//   prediction_valid_o/_o        : prediction result, one cycle after accept
//   resolve_valid/taken/ready    : execute-side resolution of the oldest branch
//   resolve_done_o/mispredicted_o: pulse one cycle after resolution accept
//   table_en/we/addr/wdata/rdata : table port, 1-cycle synchronous read
//   init_done_o                  : sweep finished, controller serving requests
module branch_predictor_controller
  import bpu_pkg::*;
#(
  parameter int TABLE_SIZE   = 1024,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic                          predict_valid_i,
  input  logic [$clog2(TABLE_SIZE)-1:0] predict_index_i,
  output logic                          predict_ready_o,
  output logic                          prediction_valid_o,
  output logic                          prediction_o,
  input  logic                          resolve_valid_i,
  input  logic                          resolve_taken_i,
  output logic                          resolve_ready_o,
  output logic                          resolve_done_o,
  output logic                          mispredicted_o,
  output logic                          table_en_o,
  output logic                          table_we_o,
  output logic [$clog2(TABLE_SIZE)-1:0] table_addr_o,
  output logic [1:0]                    table_wdata_o,
  input  logic [1:0]                    table_rdata_i,
  output logic                          init_done_o
);

  localparam int IW = $clog2(TABLE_SIZE);
  localparam int CW = $clog2(BUFFER_DEPTH) + 1;

  ctrl_state_e   state_q, state_d;
  logic [IW-1:0] sweep_q, sweep_d;
  logic          rd_pending_q, rd_pending_d;
  logic          done_q, done_d;
  logic          mispred_q, mispred_d;

  logic          run;
  logic          res_fire;
  logic          pred_fire;
  logic          commit;
  bpu_entry_t    head;
  logic [CW-1:0] count;
  logic [CW-1:0] committed;

  assign run = (state_q == ST_RUN);

  // Only entries whose counter has come back can be resolved; a resolution
  // takes the port, so it blocks a prediction in the same cycle.
  assign resolve_ready_o = run && (committed != '0);
  assign res_fire        = resolve_valid_i && resolve_ready_o;
  assign predict_ready_o = run && (count < CW'(BUFFER_DEPTH)) && !flush_i && !res_fire;
  assign pred_fire       = predict_valid_i && predict_ready_o;

  // A read response arriving during a flush belongs to a dropped entry.
  assign commit             = rd_pending_q && !flush_i;
  assign prediction_valid_o = commit;
  assign prediction_o       = commit && table_rdata_i[1];

  assign resolve_done_o = done_q;
  assign mispredicted_o = mispred_q;
  assign init_done_o    = run;

  prediction_fifo #(
    .DEPTH (BUFFER_DEPTH),
    .IW    (IW)
  ) u_fifo (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .flush_i          (flush_i && run),
    .alloc_i          (pred_fire),
    .alloc_index_i    (predict_index_i),
    .commit_i         (commit),
    .commit_counter_i (table_rdata_i),
    .pop_i            (res_fire),
    .head_o           (head),
    .count_o          (count),
    .committed_o      (committed)
  );

  // Table port: the sweep owns it in INIT (held off while reset is asserted),
  // then a resolution write has priority over a prediction read.
  always_comb begin
    table_en_o    = 1'b0;
    table_we_o    = 1'b0;
    table_addr_o  = '0;
    table_wdata_o = '0;
    if (state_q == ST_INIT) begin
      if (rst_n_i) begin
        table_en_o    = 1'b1;
        table_we_o    = 1'b1;
        table_addr_o  = sweep_q;
        table_wdata_o = WEAKLY_NOT_TAKEN;
      end
    end else if (res_fire) begin
      table_en_o    = 1'b1;
      table_we_o    = 1'b1;
      table_addr_o  = IW'(head.index);
      table_wdata_o = sat_update(head.counter, resolve_taken_i);
    end else if (pred_fire) begin
      table_en_o   = 1'b1;
      table_addr_o = predict_index_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    rd_pending_d = 1'b0;
    done_d       = 1'b0;
    mispred_d    = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + IW'(1);
        if (&sweep_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        rd_pending_d = pred_fire;
        done_d       = res_fire;
        mispred_d    = res_fire && (resolve_taken_i != head.prediction);
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      rd_pending_q <= 1'b0;
      done_q       <= 1'b0;
      mispred_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      rd_pending_q <= rd_pending_d;
      done_q       <= done_d;
      mispred_q    <= mispred_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_controller.sv
module tb_branch_predictor_controller;

  localparam int TS = 16;
  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst_n, flush, pv, rv, rt;
  logic [3:0] pidx;
  logic       pready, pvalid, pred, rready, rdone, mis;
  logic       ten, twe, idone;
  logic [3:0] taddr;
  logic [1:0] twdata, trdata;

  int checks   = 0;
  int failures = 0;

  logic [1:0] tmem [TS];

  branch_predictor_controller #(
    .TABLE_SIZE   (TS),
    .BUFFER_DEPTH (BD)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .flush_i            (flush),
    .predict_valid_i    (pv),
    .predict_index_i    (pidx),
    .predict_ready_o    (pready),
    .prediction_valid_o (pvalid),
    .prediction_o       (pred),
    .resolve_valid_i    (rv),
    .resolve_taken_i    (rt),
    .resolve_ready_o    (rready),
    .resolve_done_o     (rdone),
    .mispredicted_o     (mis),
    .table_en_o         (ten),
    .table_we_o         (twe),
    .table_addr_o       (taddr),
    .table_wdata_o      (twdata),
    .table_rdata_i      (trdata),
    .init_done_o        (idone)
  );

  always #5 clk = ~clk;

  // Single-port table with one-cycle synchronous read.
  always @(posedge clk) begin
    if (ten) begin
      if (twe) tmem[taddr] <= twdata;
      else     trdata <= tmem[taddr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Predict on an empty buffer and check the read and its result.
  task automatic do_predict(input logic [3:0] idx, input logic exp_pred);
    pv = 1'b1; pidx = idx;
    sample();
    check_eq("pred_ready", pready, 1);
    check_eq("pred_rd_en", ten, 1);
    check_eq("pred_rd_we", twe, 0);
    check_eq("pred_rd_addr", taddr, idx);
    step();
    pv = 1'b0;
    sample();
    check_eq("pred_valid", pvalid, 1);
    check_eq("pred_bit", pred, exp_pred);
    check_eq("res_ready_lag", rready, 0);
    step();
  endtask

  task automatic do_resolve(input logic taken, input logic [3:0] addr,
                            input logic [1:0] wdata, input logic exp_mis);
    rv = 1'b1; rt = taken;
    sample();
    check_eq("res_ready", rready, 1);
    check_eq("res_wr_we", twe, 1);
    check_eq("res_wr_addr", taddr, addr);
    check_eq("res_wr_data", twdata, wdata);
    step();
    rv = 1'b0;
    sample();
    check_eq("res_done", rdone, 1);
    check_eq("res_mis", mis, exp_mis);
    step();
  endtask

  int idxs [5] = '{1, 2, 3, 4, 6};

  initial begin
    rst_n = 1'b0; flush = 1'b0; pv = 1'b0; rv = 1'b0; rt = 1'b0; pidx = '0;
    trdata = '0;
    for (int i = 0; i < TS; i++) tmem[i] = 2'b11;
    step();
    step();
    sample();
    check_eq("rst_table_en", ten, 0);
    check_eq("rst_init_done", idone, 0);
    check_eq("rst_pred_ready", pready, 0);
    check_eq("rst_res_ready", rready, 0);
    check_eq("rst_pred_valid", pvalid, 0);
    check_eq("rst_res_done", rdone, 0);
    check_eq("rst_mis", mis, 0);
    step();

    // Init sweep with request noise that must be ignored.
    rst_n = 1'b1; pv = 1'b1; pidx = 4'd7; rv = 1'b1; flush = 1'b1;
    for (int i = 0; i < TS; i++) begin
      sample();
      check_eq("init_en", ten, 1);
      check_eq("init_we", twe, 1);
      check_eq("init_addr", taddr, 32'(i));
      check_eq("init_wdata", twdata, 2'b01);
      check_eq("init_pready", pready, 0);
      check_eq("init_rready", rready, 0);
      check_eq("init_done_early", idone, 0);
      step();
    end
    pv = 1'b0; rv = 1'b0; flush = 1'b0;
    sample();
    check_eq("init_done", idone, 1);
    check_eq("idle_en", ten, 0);
    for (int i = 0; i < TS; i++) check_eq("init_mem", tmem[i], 2'b01);
    step();

    // Basic predict / mispredict / re-predict.
    do_predict(4'd5, 1'b0);
    do_resolve(1'b1, 4'd5, 2'b10, 1'b1);
    do_predict(4'd5, 1'b1);
    do_resolve(1'b1, 4'd5, 2'b11, 1'b0);
    // Saturation at both ends.
    do_predict(4'd5, 1'b1);
    do_resolve(1'b1, 4'd5, 2'b11, 1'b0);
    do_predict(4'd9, 1'b0);
    do_resolve(1'b0, 4'd9, 2'b00, 1'b0);
    do_predict(4'd9, 1'b0);
    do_resolve(1'b0, 4'd9, 2'b00, 1'b0);

    // Back-to-back predicts until full, then resolve-vs-predict priority.
    for (int k = 0; k < 4; k++) begin
      pv = 1'b1; pidx = 4'(idxs[k]);
      sample();
      check_eq("b2b_ready", pready, 1);
      check_eq("b2b_addr", taddr, idxs[k]);
      if (k > 0) check_eq("b2b_pvalid", pvalid, 1);
      step();
    end
    pidx = 4'(idxs[4]);
    sample();
    check_eq("full_ready", pready, 0);
    check_eq("full_pvalid", pvalid, 1);
    check_eq("full_pred", pred, 0);
    check_eq("full_en", ten, 0);
    step();
    sample();
    check_eq("full_ready2", pready, 0);
    check_eq("full_pvalid2", pvalid, 0);
    step();
    rv = 1'b1; rt = 1'b0;
    sample();
    check_eq("prio_rready", rready, 1);
    check_eq("prio_pready", pready, 0);
    check_eq("prio_we", twe, 1);
    check_eq("prio_addr", taddr, 1);
    check_eq("prio_wdata", twdata, 2'b00);
    step();
    rv = 1'b0;
    sample();
    check_eq("after_pready", pready, 1);
    check_eq("after_en", ten, 1);
    check_eq("after_we", twe, 0);
    check_eq("after_addr", taddr, 6);
    check_eq("after_done", rdone, 1);
    check_eq("after_mis", mis, 0);
    step();
    pv = 1'b0;
    sample();
    check_eq("after_pvalid", pvalid, 1);
    check_eq("after_pred", pred, 0);
    step();
    do_resolve(1'b0, 4'd2, 2'b00, 1'b0);
    do_resolve(1'b0, 4'd3, 2'b00, 1'b0);
    do_resolve(1'b0, 4'd4, 2'b00, 1'b0);
    do_resolve(1'b0, 4'd6, 2'b00, 1'b0);

    // Flush with 3 entries, oldest resolving, one read outstanding.
    pv = 1'b1; pidx = 4'd10; step();
    pidx = 4'd11; step();
    pidx = 4'd12; step();
    pv = 1'b0; flush = 1'b1; rv = 1'b1; rt = 1'b1;
    sample();
    check_eq("fl_rready", rready, 1);
    check_eq("fl_pready", pready, 0);
    check_eq("fl_we", twe, 1);
    check_eq("fl_addr", taddr, 10);
    check_eq("fl_wdata", twdata, 2'b10);
    step();
    flush = 1'b0;
    sample();
    check_eq("fl_pvalid_next", pvalid, 0);
    check_eq("fl_done", rdone, 1);
    check_eq("fl_mis", mis, 1);
    check_eq("fl_rready_next", rready, 0);
    check_eq("fl_en_next", ten, 0);
    step();
    sample();
    check_eq("fl_rready_idle", rready, 0);
    step();
    pv = 1'b1; pidx = 4'd13;
    sample();
    check_eq("fl_new_pready", pready, 1);
    step();
    pv = 1'b0;
    sample();
    check_eq("fl_new_pvalid", pvalid, 1);
    check_eq("fl_new_pred", pred, 0);
    check_eq("fl_new_rready_lag", rready, 0);
    step();
    sample();
    check_eq("fl_new_rready", rready, 1);
    check_eq("fl_new_addr", taddr, 13);
    check_eq("fl_new_wdata", twdata, 2'b10);
    step();
    rv = 1'b0;
    sample();
    check_eq("fl_new_done", rdone, 1);
    check_eq("fl_new_mis", mis, 1);
    step();

    // Buffer must hold exactly BD entries after the flush.
    pv = 1'b1; pidx = 4'd14;
    for (int k = 0; k < BD; k++) begin
      sample();
      check_eq("refill_ready", pready, 1);
      step();
    end
    sample();
    check_eq("refill_full", pready, 0);
    step();
    pv = 1'b0;

    // Reset mid-operation restarts the sweep.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sample();
    check_eq("rerst_en", ten, 1);
    check_eq("rerst_addr", taddr, 0);
    check_eq("rerst_done", idone, 0);
    check_eq("rerst_rready", rready, 0);
    check_eq("rerst_pvalid", pvalid, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
